mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_array.sv | 43 ++++
 rtl/mem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the mem_responder slice.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES      = 4;
  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;
endpackage

// File: rtl/mem_array.sv
// Word storage with byte-enable write and a registered read port.
// The array has no reset so contents survive reset and can be preloaded.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [WORD_BYTES-1:0] wr_be,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_idx,
  input  logic                  rd_zero,
  output logic [31:0]           rd_data
);
  logic [31:0] memory [0:DEPTH-1];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (wr_be[b]) memory[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Writes and rejected accesses answer with zero instead of array data.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = rd_zero ? 32'h0 : memory[rd_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata_q <= 32'h0;
    else       rdata_q <= rdata_d;
  end

  assign rd_data = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
// Optional RAM_ALIGN_CHECK_EN adds resp_err for misaligned accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata
`ifdef RAM_ALIGN_CHECK_EN
  ,
  output logic        resp_err
`endif
);
  localparam int AW = $clog2(DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             write_q, write_d;
  logic             mis_q, mis_d;
  logic             enter_resp;
  logic             accept;
  logic             req_mis;
  logic [AW-1:0]    req_idx;
  logic [AW-1:0]    rd_idx;
  logic             rd_zero;

  assign req_idx = req_addr[AW+1:2];

`ifdef RAM_ALIGN_CHECK_EN
  assign req_mis = |req_addr[1:0];
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
`else
  assign req_mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign accept     = req_valid && (state_q == IDLE);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    mis_d      = mis_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_idx;
          write_d = req_write;
          mis_d   = req_mis;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      mis_q   <= mis_d;
    end
  end

  // With LATENCY==1 the read happens on the acceptance edge, before idx_q is loaded.
  assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_zero = (state_q == IDLE) ? (req_write || req_mis) : (write_q || mis_q);

  mem_array #(.DEPTH(DEPTH)) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept && req_write && !req_mis),
    .wr_idx  (req_idx),
    .wr_data (req_wdata),
    .wr_be   (req_be),
    .rd_en   (enter_resp),
    .rd_idx  (rd_idx),
    .rd_zero (rd_zero),
    .rd_data (resp_rdata)
  );

`ifdef RAM_ALIGN_CHECK_EN
  assign resp_err = mis_q && (state_q == RESP);
`endif
endmodule
